seg_scan_driver: RTL and testbench

Parametrised multiplexed seven-segment driver for N common-anode digits with active-low anodes and active-low segments. Each digit shows a full hex value (0-F). Adds ghost-suppression blanking between digits, per-digit blank and blink masks, and a double-buffered load handshake so the shown value only changes at frame boundaries. Sits between game/score logic and the board display pins, replacing the fixed 4-digit, 3-bit-value driver.

---
 rtl/seg_scan_driver.sv | 171 +++++++++++++++++
 tb/tb_seg_scan_driver.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Multiplexed N-digit hex seven-segment driver: ghost blanking, blank/blink masks,
// and frame-synchronised double-buffered loads. Define SEG_SCAN_LZB_EN for leading-zero blanking.
module seg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV_CNT      = 1000,
  parameter int SLOT_TICKS   = 16,
  parameter int GHOST_TICKS  = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ld,
  input  logic [4*NUM_DIGITS-1:0] din,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [0:6]              seg,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    upd_pend,
  output logic                    frame_strobe
);

  localparam int PW = $clog2(DIV_CNT);
  localparam int SW = $clog2(SLOT_TICKS);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PRESC_MAX  = PW'(DIV_CNT - 1);
  localparam logic [SW-1:0] SLOT_MAX   = SW'(SLOT_TICKS - 1);
  localparam logic [SW-1:0] GHOST_LAST = SW'(GHOST_TICKS - 1);
  localparam logic [DW-1:0] DIG_MAX    = DW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRM_MAX    = FW'(BLINK_FRAMES - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  // Scan position; the FSM state lives here so a checker can bind to one signal.
  typedef struct packed {
    state_t          state;
    logic [DW-1:0]   digit;
    logic [SW-1:0]   slot;
  } scan_t;

  function automatic logic [0:6] hex_seg(input logic [3:0] h);
    logic [0:6] s;
    case (h)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  logic [PW-1:0]           presc, presc_nxt;
  scan_t                   scan, scan_nxt;
  logic [4*NUM_DIGITS-1:0] disp, disp_nxt;
  logic [4*NUM_DIGITS-1:0] pend, pend_nxt;
  logic                    upd_nxt;
  logic [FW-1:0]           fcnt, fcnt_nxt;
  logic                    phase, phase_nxt;
  logic                    tick;
  logic                    boundary;
  logic                    show;
  logic [NUM_DIGITS-1:0]   anode_nxt;
  logic [0:6]              seg_nxt;
`ifdef SEG_SCAN_LZB_EN
  logic [DW-1:0]           lz_hi;
`endif

  always_comb begin
    tick      = (presc == PRESC_MAX);
    presc_nxt = tick ? '0 : presc + PW'(1);
    scan_nxt  = scan;
    boundary  = 1'b0;
    if (tick) begin
      if (scan.slot == SLOT_MAX) begin
        scan_nxt.slot  = '0;
        scan_nxt.state = ST_BLANK;
        scan_nxt.digit = (scan.digit == DIG_MAX) ? '0 : scan.digit + DW'(1);
        boundary       = (scan.digit == DIG_MAX);
      end else begin
        scan_nxt.slot = scan.slot + SW'(1);
        if (scan.state == ST_BLANK && scan.slot == GHOST_LAST) begin
          scan_nxt.state = ST_DRIVE;
        end
      end
    end
  end

  // A load coinciding with a boundary still transfers the older pending value.
  always_comb begin
    disp_nxt  = disp;
    pend_nxt  = pend;
    upd_nxt   = upd_pend;
    fcnt_nxt  = fcnt;
    phase_nxt = phase;
    if (boundary) begin
      if (upd_pend) begin
        disp_nxt = pend;
        upd_nxt  = 1'b0;
      end
      if (fcnt == FRM_MAX) begin
        fcnt_nxt  = '0;
        phase_nxt = ~phase;
      end else begin
        fcnt_nxt = fcnt + FW'(1);
      end
    end
    if (ld) begin
      pend_nxt = din;
      upd_nxt  = 1'b1;
    end
  end

  // Pins are computed from next-state so they move exactly on the tick edge.
  always_comb begin
    show = (scan_nxt.state == ST_DRIVE) &&
           !blank_mask[scan_nxt.digit] &&
           !(blink_mask[scan_nxt.digit] && phase_nxt);
`ifdef SEG_SCAN_LZB_EN
    lz_hi = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (disp_nxt[4*k +: 4] != 4'd0) lz_hi = DW'(k);
    end
    if (scan_nxt.digit > lz_hi) show = 1'b0;
`endif
    anode_nxt = show ? ~(NUM_DIGITS'(1) << scan_nxt.digit) : '1;
    seg_nxt   = show ? hex_seg(disp_nxt[{scan_nxt.digit, 2'b00} +: 4]) : 7'b1111111;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc        <= '0;
      scan         <= '{state: ST_BLANK, digit: '0, slot: '0};
      disp         <= '0;
      pend         <= '0;
      upd_pend     <= 1'b0;
      fcnt         <= '0;
      phase        <= 1'b0;
      frame_strobe <= 1'b0;
      anode        <= '1;
      seg          <= 7'b1111111;
    end else begin
      presc        <= presc_nxt;
      scan         <= scan_nxt;
      disp         <= disp_nxt;
      pend         <= pend_nxt;
      upd_pend     <= upd_nxt;
      fcnt         <= fcnt_nxt;
      phase        <= phase_nxt;
      frame_strobe <= boundary;
      anode        <= anode_nxt;
      seg          <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: cycle-count reference model feeds an expected queue,
// a monitor compares {upd_pend, frame_strobe, anode, seg} every clock.
module tb_seg_scan_driver;

  localparam int ND    = 4;
  localparam int DIV   = 2;
  localparam int SLOT  = 4;
  localparam int GHOST = 1;
  localparam int BLINK = 2;
  localparam int FRAME = ND * SLOT;
  localparam int OW    = 2 + ND + 7;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ld  = 1'b0;
  logic [4*ND-1:0] din = '0;
  logic [ND-1:0]   blank_mask = '0;
  logic [ND-1:0]   blink_mask = '0;
  logic [0:6]      seg;
  logic [ND-1:0]   anode;
  logic            upd_pend;
  logic            frame_strobe;

  seg_scan_driver #(
    .NUM_DIGITS(ND), .DIV_CNT(DIV), .SLOT_TICKS(SLOT),
    .GHOST_TICKS(GHOST), .BLINK_FRAMES(BLINK)
  ) dut (
    .clk(clk), .rst(rst), .ld(ld), .din(din),
    .blank_mask(blank_mask), .blink_mask(blink_mask),
    .seg(seg), .anode(anode), .upd_pend(upd_pend), .frame_strobe(frame_strobe)
  );

  always #5 clk = ~clk;

  logic [OW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: counts edges since reset release and derives scan position arithmetically.
  int              m_cyc, m_ticks, m_frames;
  logic [4*ND-1:0] m_disp, m_pend;
  logic            m_pflag;
  logic [6:0]      seg_lut [16];

  initial begin
    seg_lut = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  end

  task automatic model_reset();
    m_cyc = 0; m_ticks = 0; m_frames = 0;
    m_disp = '0; m_pend = '0; m_pflag = 1'b0;
  endtask

  function automatic logic [OW-1:0] model_outputs(input logic strobe);
    int pos, dig, s, ph, hi;
    logic show;
    logic [3:0] nib;
    logic [ND-1:0] an;
    logic [6:0] sg;
    pos = m_ticks % FRAME;
    dig = pos / SLOT;
    s   = pos % SLOT;
    ph  = (m_frames / BLINK) % 2;
    show = (s >= GHOST) && !blank_mask[dig] && !(blink_mask[dig] && ph == 1);
    hi = 0;
    for (int k = 0; k < ND; k++) if (m_disp[4*k +: 4] != 4'd0) hi = k;
`ifdef SEG_SCAN_LZB_EN
    if (dig > hi) show = 1'b0;
`endif
    nib = m_disp[4*dig +: 4];
    for (int k = 0; k < ND; k++) an[k] = !(show && k == dig);
    sg = show ? seg_lut[nib] : 7'b1111111;
    return {m_pflag, strobe, an, sg};
  endfunction

  function automatic logic next_is_boundary();
    return ((m_cyc + 1) % DIV == 0) && ((m_ticks + 1) % FRAME == 0);
  endfunction

  // Starts and ends at a negedge; drives inputs for the coming posedge.
  task automatic step(input logic ld_v, input logic [4*ND-1:0] din_v);
    logic strobe;
    ld = ld_v;
    din = din_v;
    m_cyc++;
    strobe = 1'b0;
    if (m_cyc % DIV == 0) begin
      m_ticks++;
      if (m_ticks % FRAME == 0) begin
        strobe = 1'b1;
        m_frames++;
        if (m_pflag) begin
          m_disp  = m_pend;
          m_pflag = 1'b0;
        end
      end
    end
    if (ld_v) begin
      m_pend  = din_v;
      m_pflag = 1'b1;
    end
    exp_q.push_back(model_outputs(strobe));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, din);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Called at a negedge; asserts reset between edges and checks the asynchronous response.
  task automatic apply_reset();
    ld = 1'b0;
    #2 rst = 1'b1;
    exp_q.delete();
    model_reset();
    #1;
    check("rst_anode", 32'(anode), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_upd_pend", 32'(upd_pend), 32'h0);
    check("rst_strobe", 32'(frame_strobe), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : monitor
    logic [OW-1:0] e, a;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {upd_pend, frame_strobe, anode, seg};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL pins t=%0t got upd=%b fs=%b an=%b seg=%b expected upd=%b fs=%b an=%b seg=%b",
                   $time, a[OW-1], a[OW-2], a[OW-3 -: ND], a[6:0],
                   e[OW-1], e[OW-2], e[OW-3 -: ND], e[6:0]);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int guard;
    model_reset();
    @(negedge clk);
    apply_reset();

    // Scan sequence over two frames with an all-zero display.
    idle(2 * FRAME * DIV);

    // Mid-frame load; visible only after the next boundary.
    idle(7);
    step(1'b1, 16'hA5F3);
    idle(2 * FRAME * DIV);

    // Overwrite before a boundary, then load exactly on the boundary clock.
    guard = 0;
    while (!next_is_boundary() && guard < 200) begin idle(1); guard++; end
    idle(3);
    step(1'b1, 16'h1111);
    step(1'b1, 16'h2222);
    guard = 0;
    while (!next_is_boundary() && guard < 200) begin idle(1); guard++; end
    check("boundary_found", 32'(next_is_boundary()), 32'h1);
    step(1'b1, 16'h3333);
    idle(2 * FRAME * DIV);

    // Blink and blank masks over six frames.
    blink_mask = 4'b0010;
    blank_mask = 4'b1000;
    idle(6 * FRAME * DIV);

    // Randomised loads and live mask changes.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 31) == 0) begin
        blank_mask = 4'($urandom_range(0, 15));
        blink_mask = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 7) == 0) step(1'b1, 16'($urandom));
      else idle(1);
    end
    blank_mask = '0;
    blink_mask = '0;

    // Reset during the DRIVE part of digit 2 with a load pending.
    step(1'b1, 16'h9C7E);
    guard = 0;
    while (!(((m_ticks % FRAME) / SLOT == 2) && ((m_ticks % FRAME) % SLOT >= GHOST)) && guard < 200) begin
      idle(1);
      guard++;
    end
    check("reached_digit2_drive", 32'((m_ticks % FRAME) / SLOT), 32'h2);
    step(1'b1, 16'h4444);
    apply_reset();
    idle(FRAME * DIV + 8);

    // Leading-zero cases (blanked when SEG_SCAN_LZB_EN is defined).
    step(1'b1, 16'h0040);
    idle(3 * FRAME * DIV);
    step(1'b1, 16'h0000);
    idle(3 * FRAME * DIV);
    step(1'b1, 16'h0B00);
    idle(2 * FRAME * DIV);

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
